// File: rtl/song_reader.sv
// Song sequencer: walks one 32-entry song of the song ROM, issuing each
// entry to the note player and waiting for its completion before the next fetch.
module song_reader #(
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5,
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_play,
    input  logic [SONG_BITS-1:0]          i_song,
    input  logic                          i_note_done,
    output logic [SONG_BITS+IDX_BITS-1:0] o_rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       i_rom_dout,
    output logic [NOTE_W-1:0]             o_note,
    output logic [DUR_W-1:0]              o_duration,
    output logic                          o_new_note,
    output logic                          o_song_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_BITS-1:0]  IDX_ZERO  = {IDX_BITS{1'b0}};
    localparam logic [IDX_BITS-1:0]  IDX_ONE   = {{(IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0]  IDX_LAST  = {IDX_BITS{1'b1}};
    localparam logic [SONG_BITS-1:0] SONG_ZERO = {SONG_BITS{1'b0}};
    localparam logic [NOTE_W-1:0]    NOTE_ZERO = {NOTE_W{1'b0}};
    localparam logic [DUR_W-1:0]     DUR_ZERO  = {DUR_W{1'b0}};

    logic [2:0]                   r_state;
    logic [IDX_BITS-1:0]          r_idx;
    logic [SONG_BITS-1:0]         r_song_q;
    logic [SONG_BITS+IDX_BITS-1:0] r_rom_addr;
    logic [NOTE_W-1:0]            r_note;
    logic [DUR_W-1:0]             r_duration;
    logic                         r_new_note;
    logic                         r_song_done;

    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;
    logic                w_issue;
    logic                w_advance;
    logic                w_last;
    logic [IDX_BITS-1:0] w_adv_idx;
    logic [2:0]          w_adv_state;

    assign w_rom_note = i_rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur  = i_rom_dout[DUR_W-1:0];

    // A zero-duration entry is skipped and advances exactly like a finished note.
    assign w_issue   = (r_state == S_LATCH) && (w_rom_dur != DUR_ZERO);
    assign w_advance = ((r_state == S_LATCH) && (w_rom_dur == DUR_ZERO)) ||
                       ((r_state == S_WAIT) && i_note_done && !r_new_note);

    assign w_last      = (r_idx == IDX_LAST);
    assign w_adv_idx   = w_last ? IDX_ZERO : (r_idx + IDX_ONE);
    assign w_adv_state = w_last ? S_DONE : (i_play ? S_FETCH : S_IDLE);

    // Sequencer state, entry index, ROM address and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= IDX_ZERO;
            r_song_q    <= SONG_ZERO;
            r_rom_addr  <= {SONG_ZERO, IDX_ZERO};
            r_note      <= NOTE_ZERO;
            r_duration  <= DUR_ZERO;
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_song != r_song_q) begin
                        r_song_q   <= i_song;
                        r_idx      <= IDX_ZERO;
                        r_rom_addr <= {i_song, IDX_ZERO};
                    end else if (i_play) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_state <= S_LATCH;
                end
                S_LATCH, S_WAIT: begin
                    if (w_issue) begin
                        r_note     <= w_rom_note;
                        r_duration <= w_rom_dur;
                        r_new_note <= 1'b1;
                        r_state    <= S_WAIT;
                    end else if (w_advance) begin
                        r_idx       <= w_adv_idx;
                        r_rom_addr  <= {r_song_q, w_adv_idx};
                        r_state     <= w_adv_state;
                        r_song_done <= w_last;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_DONE: begin
                    // No auto-repeat: play has to drop before a new run can start.
                    if (!i_play) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_note      = r_note;
    assign o_duration  = r_duration;
    assign o_new_note  = r_new_note;
    assign o_song_done = r_song_done;

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Sequences one song out of the 128-entry song ROM, which holds 4 songs of 32 entries.
- Each ROM word is {note[5:0], duration[5:0]} with a 1-cycle registered read.
- The block drives the ROM address, captures each entry, and hands note/duration to the downstream note player with a new_note pulse.
- It then waits for the player's note_done before fetching the next entry, and pulses song_done after the last entry.

Parameters:
- SONG_BITS, 2, song select width (4 songs)
- IDX_BITS, 5, entries per song = 2^IDX_BITS = 32
- NOTE_W, 6, note field width (ROM word bits 11:6)
- DUR_W, 6, duration field width (ROM word bits 5:0)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- play  in  1  level; 1 = run, 0 = pause after current note
- song  in  SONG_BITS  song select
- note_done  in  1  1-cycle pulse from note player: current note finished
- rom_addr  out  SONG_BITS+IDX_BITS  registered, = {song_q, idx}
- rom_dout  in  NOTE_W+DUR_W  ROM data; valid the cycle after rom_addr is presented
- note  out  NOTE_W  registered note of current entry
- duration  out  DUR_W  registered duration of current entry
- new_note  out  1  1-cycle pulse: note/duration valid, start playing
- song_done  out  1  1-cycle pulse: last entry of song completed

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, idx=0, song_q=0, rom_addr=0.
  - note=0, duration=0, new_note=0, song_done=0.
  - Reset applies from any state, including mid-note; the next edge with rst_n=1 starts from IDLE.
- States: IDLE, FETCH, LATCH, WAIT, DONE.
- IDLE:
  - If song != song_q: song_q<=song, idx<=0, stay IDLE (reselect restarts the song).
  - Else if play=1: go FETCH.
  - Otherwise hold; idx is preserved so play resumes at the paused entry.
- FETCH (1 cycle):
  - rom_addr={song_q,idx} is already stable, registered on entry.
  - Go LATCH.
- LATCH (1 cycle):
  - rom_dout is valid.
  - If rom_dout[5:0]!=0: note<=rom_dout[11:6], duration<=rom_dout[5:0], new_note<=1, go WAIT.
  - If duration field==0: the entry is skipped; no new_note, note/duration unchanged; advance as on note_done (see Advance).
- WAIT:
  - new_note is high only in the first WAIT cycle.
  - note_done is ignored in the cycle new_note=1 and in IDLE/FETCH/LATCH/DONE.
  - note_done=1 triggers Advance.
- Advance:
  - If idx==2^IDX_BITS-1: song_done<=1 for one cycle, idx<=0, go DONE.
  - Else idx<=idx+1, rom_addr updated the same edge.
    - If play=1, go FETCH.
    - If play=0, go IDLE (pause).
- DONE: wait until play=0, then go IDLE. There is no auto-repeat; play must fall and rise to replay.
- Latency: play sampled high in IDLE at edge E0 -> FETCH after E0, LATCH after E1, new_note/note/duration valid after E2. Next-entry latency from the note_done edge is the same 2 cycles.
- A skipped (duration=0) entry costs 2 cycles (FETCH+LATCH).
- Note value 0 with nonzero duration is a rest: issued normally, with no special handling.
- Index wrap: idx never exceeds 31; the 31->0 transition happens only with song_done.
- Song change outside IDLE: ignored until the reader returns to IDLE.
- play falling during FETCH/LATCH/WAIT: the current entry is still issued and completed; the reader stops before the next fetch.

Test Plan:
- Song 0, play=1 after reset -> rom_addr=0; 3 cycles later new_note=1 for exactly 1 cycle, note=49, duration=12.
- Song 1, play=1 -> first note=35/duration=36 at rom_addr=32.
  - Pulse note_done -> rom_addr=33; 2 cycles later note=42/duration=36.
  - note_done in the new_note cycle is ignored.
- Song 0 run to end: after note_done for entry 27 (note=35, duration=8), entries 28–31 (duration 0) are skipped with no new_note -> song_done pulses 8 cycles later, idx=0. With play held, no restart until play toggles 0->1.
- Pause: set play=0 during entry 5 of song 0 -> after note_done, state IDLE with idx=6 and no new_note. Set play=1 -> next note=9/duration=8 (entry 6).
- Song change in IDLE mid-song (idx=10, song 0->2) -> idx=0; next play yields note=43/duration=6 (rom_addr=64).
- Assert rst_n=0 in WAIT -> next edge: all outputs 0, state IDLE. After release, play restarts at entry 0 of song 0.
